// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave receive path.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'b00,
        DUAL   = 2'b01,
        QUAD   = 2'b10,
        RSVD   = 2'b11
    } lane_mode_e;

    typedef enum logic [1:0] {
        CMD,
        HOLD,
        DATA,
        DONE
    } rx_state_e;

    localparam int CMD_BITS = 8;

    // The reserved encoding falls back to a single lane.
    function automatic logic [2:0] lanes_of(input lane_mode_e mode);
        case (mode)
            DUAL:    return 3'd2;
            QUAD:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_rx_mc_if.sv
// Configuration, serial input and word output bundle of the multi-lane SPI receiver.
interface spi_slave_rx_mc_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 8,
    parameter int WORDS_WIDTH = 8
);
    logic [3:0]             sdi;
    logic [1:0]             mode_in;
    logic                   lsb_first_in;
    logic [CNT_WIDTH-1:0]   counter_in;
    logic [WORDS_WIDTH-1:0] words_in;
    logic                   counter_in_upd;
    logic [DATA_WIDTH-1:0]  data;
    logic                   data_ready;
    logic                   data_last;
    logic [WORDS_WIDTH-1:0] word_idx;
    logic                   rx_done;

    modport master (
        output sdi, mode_in, lsb_first_in, counter_in, words_in, counter_in_upd,
        input  data, data_ready, data_last, word_idx, rx_done
    );

    modport slave (
        input  sdi, mode_in, lsb_first_in, counter_in, words_in, counter_in_upd,
        output data, data_ready, data_last, word_idx, rx_done
    );
endinterface

// File: rtl/spi_rx_lane_shifter.sv
// Combinational next-value of the receive shift register for 1/2/4 lanes, MSB- or LSB-first.
module spi_rx_lane_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] shreg,
    input  logic [3:0]            sdi,
    input  logic [2:0]            lanes,
    input  logic [CNT_WIDTH-1:0]  cnt,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] shreg_next
);
    logic [3:0]            lane_val;
    logic [CNT_WIDTH+1:0]  shamt;
    logic [DATA_WIDTH-1:0] msb_next;

    always_comb begin
        lane_val = {3'b000, sdi[0]};
        msb_next = {shreg[DATA_WIDTH-2:0], sdi[0]};
        shamt    = {2'b00, cnt};
        case (lanes)
            3'd2: begin
                lane_val = {2'b00, sdi[1:0]};
                msb_next = {shreg[DATA_WIDTH-3:0], sdi[1:0]};
                shamt    = {1'b0, cnt, 1'b0};
            end
            3'd4: begin
                lane_val = sdi;
                msb_next = {shreg[DATA_WIDTH-5:0], sdi};
                shamt    = {cnt, 2'b00};
            end
            default: begin
            end
        endcase
        // LSB-first insertion: lane bits landing at or above DATA_WIDTH fall off the shift.
        shreg_next = lsb_first ? (shreg | (DATA_WIDTH'(lane_val) << shamt)) : msb_next;
    end
endmodule

// File: rtl/spi_slave_rx_mc.sv
// Multi-lane SPI slave receive deserialiser: 8-bit command, then programmed bursts of data words.
module spi_slave_rx_mc
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 8,
    parameter int WORDS_WIDTH = 8
) (
    input  logic               sclk,
    input  logic               cs,
    spi_slave_rx_mc_if.slave   bus
);
    rx_state_e              state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]  shreg_reg, shreg_next;
    logic [WORDS_WIDTH-1:0] word_idx_reg, word_idx_next;
    lane_mode_e             mode_reg, mode_next;
    logic                   lsb_reg, lsb_next;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;
    logic [WORDS_WIDTH-1:0] words_reg, words_next;

    logic [DATA_WIDTH-1:0]  shift_val;
    logic [2:0]             lanes;
    logic                   cmd_end, word_end, last_word, ready;

    // The command phase always uses one lane, MSB-first, regardless of the latched mode.
    assign lanes     = (state_reg == CMD) ? 3'd1 : lanes_of(mode_reg);
    assign cmd_end   = (state_reg == CMD) && (cnt_reg == CNT_WIDTH'(CMD_BITS - 1));
    assign word_end  = (state_reg == DATA) && (cnt_reg == count_reg);
    assign last_word = word_end && (word_idx_reg == words_reg);
    assign ready     = cmd_end || word_end;

    spi_rx_lane_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_shifter (
        .shreg      (shreg_reg),
        .sdi        (bus.sdi),
        .lanes      (lanes),
        .cnt        (cnt_reg),
        .lsb_first  ((state_reg == DATA) && lsb_reg),
        .shreg_next (shift_val)
    );

    assign bus.data       = ready ? shift_val : shreg_reg;
    assign bus.data_ready = ready;
    assign bus.data_last  = last_word;
    assign bus.word_idx   = word_idx_reg;
    assign bus.rx_done    = last_word || (state_reg == DONE);

    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            state_reg    <= CMD;
            cnt_reg      <= '0;
            shreg_reg    <= '0;
            word_idx_reg <= '0;
            mode_reg     <= SINGLE;
            lsb_reg      <= 1'b0;
            count_reg    <= '0;
            words_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shreg_reg    <= shreg_next;
            word_idx_reg <= word_idx_next;
            mode_reg     <= mode_next;
            lsb_reg      <= lsb_next;
            count_reg    <= count_next;
            words_reg    <= words_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shreg_next    = shreg_reg;
        word_idx_next = word_idx_reg;
        mode_next     = mode_reg;
        lsb_next      = lsb_reg;
        count_next    = count_reg;
        words_next    = words_reg;

        case (state_reg)
            CMD: begin
                shreg_next = shift_val;
                cnt_next   = cnt_reg + 1'b1;
                if (cmd_end) begin
                    cnt_next   = '0;
                    shreg_next = '0;
                    state_next = HOLD;
                end
            end
            DATA: begin
                shreg_next = shift_val;
                cnt_next   = cnt_reg + 1'b1;
                if (word_end) begin
                    cnt_next      = '0;
                    shreg_next    = '0;
                    word_idx_next = word_idx_reg + 1'b1;
                    if (last_word) state_next = DONE;
                end
            end
            default: begin
            end
        endcase

        // A parameter update wins over everything and aborts any partial word.
        if (bus.counter_in_upd) begin
            state_next    = DATA;
            cnt_next      = '0;
            shreg_next    = '0;
            word_idx_next = '0;
            mode_next     = lane_mode_e'(bus.mode_in);
            lsb_next      = bus.lsb_first_in;
            count_next    = bus.counter_in;
            words_next    = bus.words_in;
        end
    end
endmodule

// File: doc/spi_slave_rx_mc.md
# spi_slave_rx_mc

Parametrised multi-lane SPI slave receive deserialiser, the successor of the fixed single/quad receiver in the SPI slave front end. Runs entirely in the `sclk` domain with `cs` as its asynchronous reset. Captures an 8-bit single-lane command, then receives a programmed number of data words of programmed length. Supports 1/2/4 lanes, MSB- or LSB-first order, and multi-word bursts with word index and last-word flags.

## Interface

- `DATA_WIDTH`, default 32: data word width; must be ≥ 8 and a multiple of 4.
- `CNT_WIDTH`, default 8: width of the shift-cycle count.
- `WORDS_WIDTH`, default 8: width of the burst word count and word index.

Ports:

- `sclk` in 1: SPI clock; all state updates on the rising edge.
- `cs` in 1: chip select, active-high while deselected. This is the asynchronous, active-high reset.
- `sdi` in 4: serial data lanes; `sdi[0]` is the single-lane input.
- `mode_in` in 2: lane mode. `00` = 1 lane, `01` = 2 lanes, `10` = 4 lanes, `11` = 1 lane.
- `lsb_first_in` in 1: bit order for data words.
- `counter_in` in CNT_WIDTH: shift cycles per data word minus 1.
- `words_in` in WORDS_WIDTH: words per burst minus 1.
- `counter_in_upd` in 1: one-cycle strobe that latches `mode_in`, `lsb_first_in`, `counter_in` and `words_in`, then starts or restarts a burst.
- `data` out DATA_WIDTH: assembled word, right-aligned.
- `data_ready` out 1: `data` is complete this cycle.
- `data_last` out 1: the word is the last of its burst.
- `word_idx` out WORDS_WIDTH: index of the word on `data`.
- `rx_done` out 1: the burst has completed.

## Operation

The block uses four states.

- **CMD**: the state after reset.
  - Shifts `sdi[0]` MSB-first for 8 cycles.
  - On the 8th cycle, asserts `data_ready` with the command zero-extended on `data`. `data_last`=0, `word_idx`=0.
  - Then goes to HOLD.
- **HOLD**: no shifting; outputs idle. Waits for `counter_in_upd`.
- **DATA**: shifts L bits per cycle, where L is the number of lanes in the latched mode.
  - MSB-first: shreg_next = {shreg, lanes}, with the lane group ordered `sdi[L-1]`..`sdi[0]` (`sdi[L-1]` most significant).
  - LSB-first: the lane group is ORed into shreg at bit position cnt×L, with `sdi[0]` lowest.
  - Word end is the cycle where cnt == latched count. In that cycle:
    - `data_ready`=1;
    - cnt→0 and shreg→0;
    - `word_idx` increments after the word.
  - On the word where `word_idx` == latched words: `data_last`=1 and `rx_done`=1, then go to DONE.
- **DONE**: ignores `sdi`, holds all state. `rx_done` stays 1 until `cs` rises.

Width rules:
- In MSB-first mode, bits beyond DATA_WIDTH shift out of the top.
- In LSB-first mode, lane bits at positions ≥ DATA_WIDTH are dropped.
- cnt saturates nowhere: it is reset at each word end.

Boundary rules:
- `counter_in_upd` in any state goes to DATA with cnt=0, shreg=0 and `word_idx`=0, and re-latches all parameters. It aborts any partial word, which produces no `data_ready`.
- `counter_in_upd` in the CMD completion cycle: the command `data_ready` is still emitted, and the next state is DATA (not HOLD).
- `counter_in_upd` in DONE: starts a new burst.
- Latched count 0 gives one shift cycle per word.
- Latched words 0 makes every word both first and last.
- `mode_in` and `lsb_first_in` changes have no effect until the next `counter_in_upd`.

## Timing

- All outputs are combinational from current state and `sdi`. They are valid during the sclk cycle whose rising edge captures the final bit, so consumers sample on that same edge.
- `data` equals shreg_next when `data_ready`=1. Otherwise `data` is the current shreg.
- `data_ready` and `data_last` are one-cycle pulses. There is no backpressure.
- When `cs`=1, asynchronously:
  - state=CMD, cnt=0, shreg=0, `word_idx`=0 and all latched parameters are 0;
  - outputs: `data`=0, `data_ready`=0, `data_last`=0, `word_idx`=0, `rx_done`=0.
- A `cs` rise mid-word discards the partial word with no `data_ready`.
- Throughput: one word per (count+1) cycles, back-to-back with no gap cycle between words.

## Structure

- Package `spi_slave_pkg`:
  - `lane_mode_e` (SINGLE, DUAL, QUAD, RSVD);
  - state enum `rx_state_e` (CMD, HOLD, DATA, DONE);
  - `CMD_BITS`=8;
  - function lanes_of(lane_mode_e) returning 1/2/4.
- Sub-module `spi_rx_lane_shifter`, parametrised on DATA_WIDTH and CNT_WIDTH. Inputs are shreg, `sdi`, lane count, cnt and `lsb_first`; output is shreg_next. It is purely combinational and instantiated once.
- Top level holds the FSM, the counters and the parameter latches.

## Test plan

- **Command capture**: `cs` falls, `sdi[0]` carries 0xA5 MSB-first → `data_ready` on cycle 8 with `data`=0x000000A5; then HOLD, with no further `data_ready` for 10 cycles.
- **Quad MSB-first burst**: upd with `mode_in`=10, count=7, words=1; stream nibbles 1..8, then 9..F,0 → `data`=0x12345678 at `word_idx` 0, then `data`=0x9ABCDEF0 with `data_last`=1 and `rx_done`=1; further sclk edges leave `rx_done`=1 and no shifting occurs.
- **Dual LSB-first**: upd with `mode_in`=01, `lsb_first_in`=1, count=3; lane pairs 01,10,11,00 (`sdi[1]`,`sdi[0]`) → `data`=0x39.
- **Restart mid-word**: upd during cycle 3 of a 16-cycle single-lane word → no `data_ready` for the partial word; the next `data_ready` comes 16 cycles after the upd, with `word_idx`=0.
- **Reset mid-burst**: `cs` rises mid-word → all outputs 0 immediately; after `cs` falls, command capture restarts from CMD.
- **Reserved mode with upd at CMD end**: `mode_in`=11 with upd coinciding with the 8th command bit → command `data_ready` is emitted, and data is received single-lane starting on the next cycle.
